brick_scheduler: RTL and testbench
==================================

# brick_scheduler

Game-level sequencer for a pool of falling-brick slots. Decides when a new brick is spawned, which free slot receives it and at what pseudo-random x position. Drives the shared brick descent rate (`delay_done`) from a difficulty level, and counts destroyed bricks as score. Aggregates per-slot game-over into a single game state. Sits between the top-level game FSM/start button and the array of brick instances.

## Interface
- `NUM_SLOTS`, default 4: number of brick instances managed (1..8).
- `SPAWN_PERIOD`, default 25'd50_000_000: cycles between spawn attempts (≥2).
- `DELAY_INIT`, default 25'd2_000_000: `delay_done` at game start.
- `DELAY_STEP`, default 25'd125_000: decrement applied per level-up.
- `DELAY_MIN`, default 25'd250_000: floor for `delay_done`.
- `LEVEL_BRICKS`, default 8: destroyed bricks per level-up (≥1).
- `X_MAX`, default 8'd198: largest legal spawn x.
- `Y_START`, default 8'd0: spawn y.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: synchronous pulse that begins or restarts a game.
- `exist_in` in NUM_SLOTS: per-slot brick-alive flags.
- `game_over_in` in NUM_SLOTS: per-slot bottom-reached flags.
- `created` out NUM_SLOTS: one-hot, one-cycle spawn strobe.
- `spawn_x` out 8: spawn x for the strobed slot.
- `spawn_y` out 8: spawn y for the strobed slot.
- `delay_done` out 25: shared brick descent threshold.
- `score` out 16: destroyed-brick count, saturating.
- `level` out 4: difficulty level, saturating at 15.
- `game_over` out 1: game ended.

## Operation
- Reset values:
  - FSM IDLE, `created`=0, `spawn_x`=0, `spawn_y`=Y_START.
  - `delay_done`=DELAY_INIT, `score`=0, `level`=0, `game_over`=0.
  - Spawn timer 0, level counter 0, pending mask 0, LFSR=8'hA5.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle in every state. Candidate x = `lfsr` if ≤X_MAX, else `lfsr-(X_MAX+1)`.
- FSM states:
  - IDLE: wait for `start`, then go to RUN and clear score, level, level counter, timer and pending mask, and load `delay_done`=DELAY_INIT.
  - RUN:
    - Timer increments each cycle.
    - If any bit of `game_over_in & exist_in` is set, go to OVER. This has priority over spawn.
    - Otherwise, at timer==SPAWN_PERIOD-1, clear the timer and go to SPAWN.
  - SPAWN (one cycle):
    - `created` is high for the lowest-index slot with `exist_in`=0 and pending=0, and `spawn_x` is loaded from the candidate.
    - If no slot is free, `created` stays 0 (spawn skipped) and `spawn_x` is unchanged.
    - Always returns to RUN. The timer keeps counting from 0.
  - OVER: `game_over`=1 and no spawns. `start` restarts exactly as from IDLE and clears `game_over`.
- Pending mask: a strobed slot is marked pending for 4 cycles, or until its `exist_in` rises, whichever is first. This prevents a double spawn into a slot that has not yet reported alive.
- Scoring (RUN and SPAWN only):
  - Falling edges of `exist_in` against a registered copy are counted, popcount per cycle.
  - `score` += count, saturating at 16'hFFFF.
  - Level counter += count. When it reaches ≥LEVEL_BRICKS, subtract LEVEL_BRICKS, `level` += 1 (saturate at 15), and `delay_done` = max(`delay_done`−DELAY_STEP, DELAY_MIN). At most one level-up per cycle.
  - The subtraction must not underflow: compare before subtracting.
- `start` while in RUN or SPAWN is ignored.

## Timing
- `created`, `spawn_x` and `spawn_y` are registered and change on the edge entering SPAWN. `created` is high exactly during the SPAWN cycle. `spawn_x` holds until the next successful spawn.
- Spawn strobes are spaced SPAWN_PERIOD+1 cycles apart.
- Score, level and `delay_done` update one cycle after the `exist_in` falling edge is sampled.
- `game_over` rises on the edge entering OVER, one cycle after the qualifying input is sampled.
- An asynchronous reset mid-game, including during SPAWN, forces all reset values immediately and deasserts `created`.

## Configuration
- `BRICK_SCHED_LEVEL_EN` defined: the difficulty ramp (level and `delay_done` update) is compiled in.
- Not defined: `level` is tied to 0 and `delay_done` is constant at DELAY_INIT. Scoring and spawning are unchanged.

## Test plan
Bench parameters: NUM_SLOTS=2, SPAWN_PERIOD=8, LEVEL_BRICKS=2, DELAY_INIT=100, DELAY_STEP=40, DELAY_MIN=30, X_MAX=198; macro defined unless stated.

- **First spawn:** reset, pulse `start`, `exist_in`=00 -> `created`=01 for one cycle, 9 cycles after RUN entry. `spawn_x` matches the LFSR model and is ≤198. `spawn_y`=0.
- **Skipped spawn:** `exist_in`=11 at the spawn point -> `created` stays 00 and `spawn_x` is unchanged. Next attempt with `exist_in`=01 -> `created`=10.
- **Level ramp:** `exist_in` 11->00 in one cycle -> `score`=2, `level`=1, `delay_done`=60. Repeat -> 4/2/30. Repeat -> 6/3/30 (floor holds).
- **Game over priority:** `game_over_in`=01 and `exist_in`=01 on the spawn-terminal cycle -> OVER, no `created`, `game_over`=1. `start` -> `score`=0, `level`=0, `delay_done`=100, `game_over`=0.
- **Reset mid-spawn:** assert `rst`=0 during the SPAWN cycle -> `created`=00 immediately and all outputs at their reset values.
- **Macro off:** run the level-ramp stimulus -> `score`=6, `level`=0, `delay_done`=100.

Source files
------------

// File: rtl/brick_scheduler.sv
// Spawn/score/difficulty sequencer for a pool of falling-brick slots.
// Define BRICK_SCHED_LEVEL_EN to compile in the level / descent-rate ramp.
module brick_scheduler #(
  parameter int          NUM_SLOTS    = 4,
  parameter logic [24:0] SPAWN_PERIOD = 25'd50_000_000,
  parameter logic [24:0] DELAY_INIT   = 25'd2_000_000,
  parameter logic [24:0] DELAY_STEP   = 25'd125_000,
  parameter logic [24:0] DELAY_MIN    = 25'd250_000,
  parameter int          LEVEL_BRICKS = 8,
  parameter logic [7:0]  X_MAX        = 8'd198,
  parameter logic [7:0]  Y_START      = 8'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_SLOTS-1:0] exist_in,
  input  logic [NUM_SLOTS-1:0] game_over_in,
  output logic [NUM_SLOTS-1:0] created,
  output logic [7:0]           spawn_x,
  output logic [7:0]           spawn_y,
  output logic [24:0]          delay_done,
  output logic [15:0]          score,
  output logic [3:0]           level,
  output logic                 game_over
);

  typedef enum logic [1:0] {IDLE, RUN, SPAWN, OVER} state_t;

  state_t               state, state_nxt;
  logic [24:0]          timer;
  logic [7:0]           lfsr;
  logic [7:0]           cand;
  logic [NUM_SLOTS-1:0] exist_q;
  logic [2:0]           pend_cnt [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] pending;
  logic [NUM_SLOTS-1:0] pick;
  logic [3:0]           fall_cnt;
  logic [16:0]          score_sum;
  logic                 restart, scoring, timer_done, hit_over;

  function automatic logic [3:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  function automatic logic [NUM_SLOTS-1:0] lowest_one(input logic [NUM_SLOTS-1:0] v);
    logic [NUM_SLOTS-1:0] r;
    logic                 found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) pending[i] = (pend_cnt[i] != 3'd0);
  end

  assign cand       = (lfsr > X_MAX) ? lfsr - (X_MAX + 8'd1) : lfsr;
  assign timer_done = (timer == SPAWN_PERIOD - 25'd1);
  assign hit_over   = |(game_over_in & exist_in);
  assign scoring    = (state == RUN) || (state == SPAWN);
  assign fall_cnt   = popcount(exist_q & ~exist_in);
  assign score_sum  = {1'b0, score} + 17'(fall_cnt);

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    pick      = '0;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          restart   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (hit_over) begin
          state_nxt = OVER;
        end else if (timer_done) begin
          state_nxt = SPAWN;
          pick      = lowest_one(~exist_in & ~pending);
        end
      end
      SPAWN:   state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= 25'd0;
      lfsr      <= 8'hA5;
      exist_q   <= '0;
      created   <= '0;
      spawn_x   <= 8'd0;
      spawn_y   <= Y_START;
      score     <= 16'd0;
      game_over <= 1'b0;
    end else begin
      state   <= state_nxt;
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      exist_q <= exist_in;
      created <= pick;
      if (|pick) begin
        spawn_x <= cand;
        spawn_y <= Y_START;
      end
      if (restart)
        timer <= 25'd0;
      else if (state == RUN)
        timer <= timer_done ? 25'd0 : timer + 25'd1;
      if (restart)
        game_over <= 1'b0;
      else if (state == RUN && hit_over)
        game_over <= 1'b1;
      if (restart)
        score <= 16'd0;
      else if (scoring)
        score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  // A freshly strobed slot stays reserved until it reports alive or 4 cycles pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) pend_cnt[i] <= 3'd0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (restart)
          pend_cnt[i] <= 3'd0;
        else if (pick[i])
          pend_cnt[i] <= 3'd4;
        else if (pend_cnt[i] != 3'd0)
          pend_cnt[i] <= (exist_in[i] && !exist_q[i]) ? 3'd0 : pend_cnt[i] - 3'd1;
      end
    end
  end

`ifdef BRICK_SCHED_LEVEL_EN
  localparam logic [16:0] LVL_BRICKS = 17'(LEVEL_BRICKS);

  logic [15:0] lvl_cnt;
  logic [16:0] lvl_sum;

  assign lvl_sum = {1'b0, lvl_cnt} + 17'(fall_cnt);

  // Threshold is checked before subtracting so neither counter can wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_cnt    <= 16'd0;
      level      <= 4'd0;
      delay_done <= DELAY_INIT;
    end else if (restart) begin
      lvl_cnt    <= 16'd0;
      level      <= 4'd0;
      delay_done <= DELAY_INIT;
    end else if (scoring) begin
      if (lvl_sum >= LVL_BRICKS) begin
        lvl_cnt <= 16'(lvl_sum - LVL_BRICKS);
        if (level != 4'd15) level <= level + 4'd1;
        if ({1'b0, delay_done} >= {1'b0, DELAY_MIN} + {1'b0, DELAY_STEP})
          delay_done <= delay_done - DELAY_STEP;
        else
          delay_done <= DELAY_MIN;
      end else begin
        lvl_cnt <= lvl_sum[15:0];
      end
    end
  end
`else
  assign level      = 4'd0;
  assign delay_done = DELAY_INIT;
`endif

endmodule

// File: tb/tb_brick_scheduler.sv
// Directed bench for brick_scheduler: spawn timing, skip, level ramp, game over, reset.
module tb_brick_scheduler;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  exist_in, game_over_in;
  logic [1:0]  created;
  logic [7:0]  spawn_x, spawn_y;
  logic [24:0] delay_done;
  logic [15:0] score;
  logic [3:0]  level;
  logic        game_over;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  brick_scheduler #(
    .NUM_SLOTS(2), .SPAWN_PERIOD(25'd8), .DELAY_INIT(25'd100), .DELAY_STEP(25'd40),
    .DELAY_MIN(25'd30), .LEVEL_BRICKS(2), .X_MAX(8'd198), .Y_START(8'd0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .exist_in(exist_in), .game_over_in(game_over_in),
    .created(created), .spawn_x(spawn_x), .spawn_y(spawn_y), .delay_done(delay_done),
    .score(score), .level(level), .game_over(game_over)
  );

  // Reference LFSR; m_prev holds the value the DUT used on the most recent edge.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  function automatic logic [7:0] cand(input logic [7:0] v);
    return (v > 8'd198) ? v - 8'd199 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] score;
    logic [3:0]  level;
    logic [24:0] delay;
  } ramp_t;

  ramp_t      ramp [3];
  logic [7:0] sx;
  int         strobes;
  bit         seen;

  initial begin
`ifdef BRICK_SCHED_LEVEL_EN
    ramp[0] = '{16'd2, 4'd1, 25'd60};
    ramp[1] = '{16'd4, 4'd2, 25'd30};
    ramp[2] = '{16'd6, 4'd3, 25'd30};
`else
    ramp[0] = '{16'd2, 4'd0, 25'd100};
    ramp[1] = '{16'd4, 4'd0, 25'd100};
    ramp[2] = '{16'd6, 4'd0, 25'd100};
`endif
    rst = 1'b0; start = 1'b0; exist_in = 2'b00; game_over_in = 2'b00;
    @(negedge clk);
    check("rst_created", 32'(created), 32'd0);
    check("rst_spawn_x", 32'(spawn_x), 32'd0);
    check("rst_spawn_y", 32'(spawn_y), 32'd0);
    check("rst_delay", 32'(delay_done), 32'd100);
    check("rst_score", 32'(score), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);

    rst = 1'b1;
    tick(); tick();
    check("idle_no_spawn", 32'(created), 32'd0);

    // First spawn: SPAWN is the 9th cycle after the start edge.
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    check("pre_spawn_quiet", 32'(created), 32'd0);
    tick();
    check("first_created", 32'(created), 32'd1);
    check("first_spawn_x", 32'(spawn_x), 32'(cand(m_prev)));
    check("first_x_in_range", 32'(spawn_x <= 8'd198), 32'd1);
    check("first_spawn_y", 32'(spawn_y), 32'd0);
    tick();
    check("strobe_one_cycle", 32'(created), 32'd0);

    // Skipped spawn with both slots alive, then slot 1 free.
    exist_in = 2'b11;
    sx = spawn_x;
    repeat (8) tick();
    check("skip_created", 32'(created), 32'd0);
    check("skip_x_held", 32'(spawn_x), 32'(sx));
    exist_in = 2'b01;
    repeat (9) tick();
    check("second_created", 32'(created), 32'd2);
    check("second_spawn_x", 32'(spawn_x), 32'(cand(m_prev)));

    // Game over asserted on the spawn-terminal cycle wins over the spawn.
    repeat (8) tick();
    game_over_in = 2'b01;
    tick();
    check("over_flag", 32'(game_over), 32'd1);
    check("over_no_created", 32'(created), 32'd0);
    strobes = 0;
    repeat (12) begin
      tick();
      if (created != 2'b00) strobes++;
    end
    check("over_no_spawns", 32'(strobes), 32'd0);
    check("over_score_kept", 32'(score), 32'd1);
    game_over_in = 2'b00;
    start = 1'b1; tick(); start = 1'b0;
    check("restart_score", 32'(score), 32'd0);
    check("restart_level", 32'(level), 32'd0);
    check("restart_delay", 32'(delay_done), 32'd100);
    check("restart_game_over", 32'(game_over), 32'd0);

    // Level ramp: two bricks destroyed in one cycle per step.
    for (int i = 0; i < 3; i++) begin
      exist_in = 2'b11; tick(); tick();
      exist_in = 2'b00; tick(); tick();
      check($sformatf("ramp%0d_score", i), 32'(score), 32'(ramp[i].score));
      check($sformatf("ramp%0d_level", i), 32'(level), 32'(ramp[i].level));
      check($sformatf("ramp%0d_delay", i), 32'(delay_done), 32'(ramp[i].delay));
    end

    // Asynchronous reset in the middle of a SPAWN cycle.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (created != 2'b00) seen = 1'b1;
    end
    check("mid_spawn_reached", 32'(seen), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_created", 32'(created), 32'd0);
    check("midrst_spawn_x", 32'(spawn_x), 32'd0);
    check("midrst_spawn_y", 32'(spawn_y), 32'd0);
    check("midrst_score", 32'(score), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_delay", 32'(delay_done), 32'd100);
    check("midrst_game_over", 32'(game_over), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_idle", 32'(created), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
